// File: rtl/mc_control_fsm_pkg.sv
// Shared constants for the multicycle control unit: opcode map, FSM states,
// ALU operation encodings and datapath select encodings.
package mc_pkg;

    localparam logic [2:0] OP_LD   = 3'b000;
    localparam logic [2:0] OP_ST   = 3'b001;
    localparam logic [2:0] OP_ADDI = 3'b010;
    localparam logic [2:0] OP_BEQ  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_AND  = 3'b110;
    localparam logic [2:0] OP_OR   = 3'b111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic ADDR_PC  = 1'b0;
    localparam logic ADDR_IMM = 1'b1;
    localparam logic WSEL_ALU = 1'b0;
    localparam logic WSEL_MEM = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_ALUWB,
        S_MEM,
        S_LDWB,
        S_BRANCH
    } state_e;

    // ALU function needed by an opcode; BEQ compares by subtraction.
    function automatic logic [1:0] alu_op_for(input logic [2:0] op);
        logic [1:0] r;
        r = ALU_ADD;
        case (op)
            OP_ADDI: r = ALU_ADD;
            OP_BEQ:  r = ALU_SUB;
            OP_ADD:  r = ALU_ADD;
            OP_SUB:  r = ALU_SUB;
            OP_AND:  r = ALU_AND;
            OP_OR:   r = ALU_OR;
            default: r = ALU_ADD;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control-unit bundle: decoder/memory/ALU inputs and datapath control outputs.
// Handshake: mem_req is held high until the cycle mem_ready=1 completes the access; mem_ready with mem_req=0 is ignored.
interface mc_control_fsm_if #(
    parameter int RETIRE_W = 32
) ();
    logic                run;
    logic [2:0]          opcode;
    logic                alu_zero;
    logic                mem_ready;
    logic                mem_req;
    logic                mem_we;
    logic                mem_addr_sel;
    logic                ir_load;
    logic                pc_inc;
    logic                pc_load;
    logic                rf_we;
    logic                rf_wsel;
    logic                alu_src;
    logic [1:0]          alu_op;
    logic                instr_done;
    logic                busy;
    logic [RETIRE_W-1:0] retired;

    modport master (
        input  run, opcode, alu_zero, mem_ready,
        output mem_req, mem_we, mem_addr_sel, ir_load, pc_inc, pc_load,
               rf_we, rf_wsel, alu_src, alu_op, instr_done, busy, retired
    );

    modport slave (
        output run, opcode, alu_zero, mem_ready,
        input  mem_req, mem_we, mem_addr_sel, ir_load, pc_inc, pc_load,
               rf_we, rf_wsel, alu_src, alu_op, instr_done, busy, retired
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle control FSM: fetch/decode/execute/memory/write-back sequencing
// with a variable-latency memory handshake and a retired-instruction counter.
module mc_control_fsm
    import mc_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    mc_control_fsm_if.master  bus,
    output state_e            state_o
);

    state_e              state_q;
    logic [2:0]          op_q;
    logic [RETIRE_W-1:0] retired_q;
    logic                done;

    // Outputs decode from the state register; memory completion and the branch
    // flag feed straight through so the handshake costs no extra cycle.
    always_comb begin
        bus.mem_req      = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_addr_sel = ADDR_PC;
        bus.ir_load      = 1'b0;
        bus.pc_inc       = 1'b0;
        bus.pc_load      = 1'b0;
        bus.rf_we        = 1'b0;
        bus.rf_wsel      = WSEL_ALU;
        bus.alu_src      = 1'b0;
        bus.alu_op       = ALU_ADD;
        done             = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.mem_req = 1'b1;
                bus.ir_load = bus.mem_ready;
                bus.pc_inc  = bus.mem_ready;
            end
            S_EXEC: begin
                bus.alu_op  = alu_op_for(op_q);
                bus.alu_src = (op_q == OP_ADDI);
            end
            S_ALUWB: begin
                bus.alu_op  = alu_op_for(op_q);
                bus.alu_src = (op_q == OP_ADDI);
                bus.rf_we   = 1'b1;
                bus.rf_wsel = WSEL_ALU;
                done        = 1'b1;
            end
            S_MEM: begin
                bus.mem_req      = 1'b1;
                bus.mem_addr_sel = ADDR_IMM;
                bus.mem_we       = (op_q == OP_ST);
                done             = bus.mem_ready && (op_q == OP_ST);
            end
            S_LDWB: begin
                bus.rf_we   = 1'b1;
                bus.rf_wsel = WSEL_MEM;
                done        = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_op  = ALU_SUB;
                bus.alu_src = 1'b0;
                bus.pc_load = bus.alu_zero;
                done        = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= OP_LD;
            retired_q <= '0;
        end else if (done) begin
            retired_q <= retired_q + {{(RETIRE_W-1){1'b0}}, 1'b1};
            state_q   <= bus.run ? S_FETCH : S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (bus.run) state_q <= S_FETCH;
                S_FETCH:  if (bus.mem_ready) state_q <= S_DECODE;
                S_DECODE: begin
                    op_q <= bus.opcode;
                    case (bus.opcode)
                        OP_LD, OP_ST: state_q <= S_MEM;
                        OP_BEQ:       state_q <= S_BRANCH;
                        default:      state_q <= S_EXEC;
                    endcase
                end
                S_EXEC:   state_q <= S_ALUWB;
                S_MEM:    if (bus.mem_ready) state_q <= S_LDWB;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.instr_done = done;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.retired    = retired_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed scenarios plus randomized instruction
// streams checked against per-instruction expectations from the opcode rules.
module tb_mc_control_fsm;
    import mc_pkg::*;

    localparam int RW = 4;

    logic   clk;
    logic   rst_n;
    state_e state;
    int     checks;
    int     errors;
    int     model_retired;
    state_e st_trace[$];

    mc_control_fsm_if #(.RETIRE_W(RW)) bif ();

    mc_control_fsm #(.RETIRE_W(RW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bif),
        .state_o (state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_mem_req"},  32'(bif.mem_req), 0);
        chk({tag, "_mem_we"},   32'(bif.mem_we), 0);
        chk({tag, "_addr_sel"}, 32'(bif.mem_addr_sel), 0);
        chk({tag, "_ir_load"},  32'(bif.ir_load), 0);
        chk({tag, "_pc_inc"},   32'(bif.pc_inc), 0);
        chk({tag, "_pc_load"},  32'(bif.pc_load), 0);
        chk({tag, "_rf_we"},    32'(bif.rf_we), 0);
        chk({tag, "_rf_wsel"},  32'(bif.rf_wsel), 0);
        chk({tag, "_alu_src"},  32'(bif.alu_src), 0);
        chk({tag, "_alu_op"},   32'(bif.alu_op), 0);
        chk({tag, "_done"},     32'(bif.instr_done), 0);
        chk({tag, "_busy"},     32'(bif.busy), 0);
        chk({tag, "_retired"},  32'(bif.retired), 0);
        chk({tag, "_state"},    32'(state), 32'(S_IDLE));
    endtask

    // Reference rules, stated per opcode
    function automatic int exp_cycles(input int op, input int fw, input int mw);
        case (op)
            0:       return 4 + fw + mw;
            1:       return 3 + fw + mw;
            3:       return 3 + fw;
            default: return 4 + fw;
        endcase
    endfunction

    function automatic int exp_alu(input int op);
        if (op == 2) return 0;
        if (op == 3) return 1;
        return op - 4;
    endfunction

    // Runs one instruction starting at a negedge; returns at the negedge after
    // its last cycle. fw/mw are wait cycles for fetch and data accesses.
    task automatic run_instr(input int op, input int fw, input int mw, input bit z,
                             input int drop_in);
        int  cyc, acc, waited, tgt, guard;
        int  n_ir, n_pci, n_pcl, n_rf, n_we, n_req, n_sel;
        bit  done;
        bit  is_mem;
        string t;
        cyc = 0; acc = 0; waited = 0; guard = 0; done = 0;
        n_ir = 0; n_pci = 0; n_pcl = 0; n_rf = 0; n_we = 0; n_req = 0; n_sel = 0;
        is_mem = (op == 0) || (op == 1);
        t = $sformatf("op%0d_fw%0d_mw%0d", op, fw, mw);
        st_trace.delete();
        bif.opcode = 3'(op);
        while (!done && guard < 200) begin
            guard++;
            bif.alu_zero = z;
            if (bif.mem_req) begin
                tgt = (acc == 0) ? fw : mw;
                if (waited == tgt) begin
                    bif.mem_ready = 1'b1;
                    acc++;
                    waited = 0;
                end else begin
                    bif.mem_ready = 1'b0;
                    waited++;
                end
            end else begin
                bif.mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            if (bif.busy) begin
                cyc++;
                st_trace.push_back(state);
                n_ir  += int'(bif.ir_load);
                n_pci += int'(bif.pc_inc);
                n_pcl += int'(bif.pc_load);
                n_rf  += int'(bif.rf_we);
                n_we  += int'(bif.mem_we);
                n_req += int'(bif.mem_req);
                n_sel += int'(bif.mem_addr_sel);
                chk({t, "_pcinc_pcload"}, 32'(bif.pc_inc & bif.pc_load), 0);
                chk({t, "_irload_rfwe"}, 32'(bif.ir_load & bif.rf_we), 0);
                if (bif.rf_we) begin
                    chk({t, "_rf_wsel"}, 32'(bif.rf_wsel), (op == 0) ? 1 : 0);
                    if (op != 0) begin
                        chk({t, "_alu_op_wb"}, 32'(bif.alu_op), 32'(exp_alu(op)));
                        chk({t, "_alu_src_wb"}, 32'(bif.alu_src), (op == 2) ? 1 : 0);
                    end
                end
                if (bif.instr_done) begin
                    done = 1'b1;
                    if (op == 3) begin
                        chk({t, "_beq_alu_op"}, 32'(bif.alu_op), 1);
                        chk({t, "_beq_alu_src"}, 32'(bif.alu_src), 0);
                    end
                    if (op == 1) chk({t, "_st_done_ready"}, 32'(bif.mem_ready), 1);
                end
                if (cyc == drop_in) bif.run = 1'b0;
            end
            @(negedge clk);
        end
        bif.mem_ready = 1'b0;
        chk({t, "_completed"}, 32'(done), 1);
        chk({t, "_cycles"}, 32'(cyc), 32'(exp_cycles(op, fw, mw)));
        chk({t, "_ir_load_n"}, 32'(n_ir), 1);
        chk({t, "_pc_inc_n"}, 32'(n_pci), 1);
        chk({t, "_pc_load_n"}, 32'(n_pcl), (op == 3 && z) ? 1 : 0);
        chk({t, "_rf_we_n"}, 32'(n_rf), (op == 1 || op == 3) ? 0 : 1);
        chk({t, "_mem_we_n"}, 32'(n_we), (op == 1) ? 32'(mw + 1) : 0);
        chk({t, "_mem_req_n"}, 32'(n_req), 32'(fw + 1 + (is_mem ? mw + 1 : 0)));
        chk({t, "_addr_sel_n"}, 32'(n_sel), is_mem ? 32'(mw + 1) : 0);
        model_retired = (model_retired + 1) % (1 << RW);
        chk({t, "_retired"}, 32'(bif.retired), 32'(model_retired));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_retired = 0;
        rst_n = 1'b0;
        bif.run = 1'b0;
        bif.opcode = 3'b000;
        bif.alu_zero = 1'b0;
        bif.mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("idle_no_run_state", 32'(state), 32'(S_IDLE));
        @(negedge clk);

        // Directed: ADD zero wait with state trace
        bif.run = 1'b1;
        run_instr(4, 0, 0, 1'b0, -1);
        chk("add_trace_len", 32'(st_trace.size()), 4);
        if (st_trace.size() == 4) begin
            chk("add_trace0", 32'(st_trace[0]), 32'(S_FETCH));
            chk("add_trace1", 32'(st_trace[1]), 32'(S_DECODE));
            chk("add_trace2", 32'(st_trace[2]), 32'(S_EXEC));
            chk("add_trace3", 32'(st_trace[3]), 32'(S_ALUWB));
        end

        // Directed: LD with 3 data wait cycles, ST, BEQ taken/not taken
        run_instr(0, 0, 3, 1'b0, -1);
        run_instr(1, 0, 0, 1'b0, -1);
        run_instr(3, 0, 0, 1'b1, -1);
        run_instr(3, 0, 0, 1'b0, -1);
        run_instr(2, 2, 0, 1'b0, -1);

        // Randomized stream; retired wraps several times at RW=4
        for (int i = 0; i < 40; i++) begin
            run_instr(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1);
        end

        // run dropped during EXEC: instruction finishes, then park in IDLE
        run_instr(5, 0, 0, 1'b0, 3);
        #1;
        chk("drop_busy", 32'(bif.busy), 0);
        chk("drop_state", 32'(state), 32'(S_IDLE));
        @(negedge clk);
        #1;
        chk("drop_stays_idle", 32'(state), 32'(S_IDLE));

        // Reset during LD data wait
        bif.opcode = OP_LD;
        bif.mem_ready = 1'b0;
        bif.run = 1'b1;
        @(negedge clk);
        bif.mem_ready = 1'b1;
        @(negedge clk);
        bif.mem_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("ldrst_in_mem", 32'(state), 32'(S_MEM));
        chk("ldrst_req", 32'(bif.mem_req), 1);
        chk("ldrst_sel", 32'(bif.mem_addr_sel), 1);
        rst_n = 1'b0;
        bif.run = 1'b0;
        @(negedge clk);
        #1;
        chk_outputs_zero("ldrst");
        model_retired = 0;
        rst_n = 1'b1;
        bif.mem_ready = 1'b1;
        #1;
        chk("stray_ir_load", 32'(bif.ir_load), 0);
        chk("stray_rf_we", 32'(bif.rf_we), 0);
        @(negedge clk);
        #1;
        chk("stray_state", 32'(state), 32'(S_IDLE));
        chk("stray_rf_we2", 32'(bif.rf_we), 0);
        bif.mem_ready = 1'b0;
        @(negedge clk);

        // Recovery after reset
        bif.run = 1'b1;
        run_instr(6, 1, 0, 1'b0, -1);
        run_instr(0, 0, 0, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Multicycle control unit: sequences fetch, decode, execute, memory and write-back for every instruction, driven by the 3-bit opcode that the instruction decoder extracts from the instruction register.
- Sits directly downstream of the decoder.
- Drives the instruction register, PC, register file, ALU and the shared instruction/data memory port.
- Uses a variable-latency memory handshake and keeps a retired-instruction counter.

Parameters:
RETIRE_W, 32, width of retired-instruction counter (wraps modulo 2^RETIRE_W)

Ports:
clk  in  1  system clock; all state changes on rising edge
rst_n  in  1  synchronous reset, active-low
run  in  1  level; 1 allows fetches to start, 0 parks in IDLE at the next instruction boundary
opcode  in  3  decoder opcode; valid from the DECODE cycle onward
alu_zero  in  1  ALU result==0 flag, sampled in BRANCH
mem_ready  in  1  memory completion strobe for the current mem_req
mem_req  out  1  memory access request, held until mem_ready
mem_we  out  1  write enable qualifying mem_req (ST only)
mem_addr_sel  out  1  0=PC, 1=decoder addr field
ir_load  out  1  load instruction register from memory read data
pc_inc  out  1  PC <= PC+1
pc_load  out  1  PC <= decoder addr (taken branch)
rf_we  out  1  register file write, destination reg_addr_0
rf_wsel  out  1  0=ALU result, 1=memory read data
alu_src  out  1  0=reg_addr_2 operand, 1=zero-extended immediate addr
alu_op  out  2  00=ADD, 01=SUB, 10=AND, 11=OR
instr_done  out  1  one-cycle pulse on the last cycle of each instruction
busy  out  1  1 in every state except IDLE
retired  out  RETIRE_W  count of instr_done pulses since reset

Behaviour:
- Opcode map:
  - 000 LD: r0 <= mem[addr]
  - 001 ST: mem[addr] <= r0
  - 010 ADDI: r0 <= r1 + imm
  - 011 BEQ: if r0==r1, PC <= addr
  - 100 ADD, 101 SUB, 110 AND, 111 OR: r0 <= r1 op r2
- States: IDLE, FETCH, DECODE, EXEC, ALUWB, MEM, LDWB, BRANCH.
- Reset (rst_n=0 at an edge):
  - state = IDLE, op_q = 000, retired = 0.
  - All outputs 0.
  - Any outstanding mem_req is dropped immediately, including mid-access; a later mem_ready is ignored.
- IDLE: if run=1, go to FETCH next cycle, else stay.
- FETCH:
  - Drives mem_req=1, mem_addr_sel=0, mem_we=0.
  - While mem_ready=0: stay; all other outputs 0.
  - On the cycle mem_ready=1: assert ir_load=1 and pc_inc=1 (combinational, same cycle), then go to DECODE.
- DECODE (1 cycle):
  - Register op_q <= opcode.
  - Next state by opcode: 000/001 -> MEM; 011 -> BRANCH; others -> EXEC.
  - No outputs asserted.
- EXEC (1 cycle): alu_op and alu_src from op_q.
  - ADDI: alu_op=00, alu_src=1.
  - ADD/SUB/AND/OR: alu_op=00/01/10/11, alu_src=0.
  - Next: ALUWB.
- ALUWB (1 cycle): rf_we=1, rf_wsel=0, alu_op/alu_src held as in EXEC, instr_done=1.
- MEM:
  - Drives mem_req=1, mem_addr_sel=1, mem_we=(op_q==001).
  - Waits for mem_ready.
  - On mem_ready: ST asserts instr_done=1 in that cycle and ends; LD goes to LDWB.
- LDWB (1 cycle): rf_we=1, rf_wsel=1, instr_done=1.
- BRANCH (1 cycle): alu_op=01, alu_src=0, pc_load=alu_zero, instr_done=1.
- End of instruction: every state asserting instr_done goes to FETCH if run=1, else IDLE.
- Latency with zero-wait memory (mem_ready=1 on the first request cycle): ALU/ADDI 4 cycles, LD 4, ST 3, BEQ 3.
- Each wait cycle adds 1 cycle.
- mem_req never drops before mem_ready, and mem_ready while mem_req=0 is ignored.
- run=0 mid-instruction has no effect until the instruction boundary.
- retired increments on each instruction boundary and wraps from all-ones to 0.
- pc_inc and pc_load are never asserted in the same cycle; ir_load and rf_we are never asserted in the same cycle.

Decomposition:
- Shared package mc_pkg holds:
  - opcode constants OP_LD..OP_OR;
  - the state enum/localparams;
  - ALU_ADD/SUB/AND/OR encodings;
  - select encodings (ADDR_PC/ADDR_IMM, WSEL_ALU/WSEL_MEM).
- Single module; no sub-module. Retire counter and FSM stay inline.

Test Plan:
- Reset then run=1, ADD (100) with zero-wait memory -> FETCH,DECODE,EXEC,ALUWB; rf_we=1 in cycle 4 with alu_op=00, alu_src=0; retired=1.
- LD (000) with mem_ready delayed 3 cycles in MEM -> mem_req=1, mem_addr_sel=1 held for 4 cycles; LDWB rf_wsel=1; instruction total 7 cycles.
- ST (001) -> mem_we=1 only in MEM; instr_done coincides with mem_ready; rf_we never 1; 3 cycles at zero wait.
- BEQ (011) with alu_zero=1, then again with alu_zero=0 -> pc_load=1 in BRANCH for the first, 0 for the second; pc_inc only in FETCH.
- rst_n=0 during MEM wait of an LD -> next cycle all outputs 0, state IDLE, retired=0; a stray mem_ready afterwards causes no ir_load or rf_we.
- run dropped during EXEC -> ALUWB completes, state goes IDLE, busy=0; with retired preloaded near all-ones via 2^RETIRE_W instructions (RETIRE_W=4 build), counter wraps 15->0.
